// File: rtl/count_run_arbiter_pkg.sv
// Shared types and constants for the count-run arbiter and its encoder.
package count_run_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic MODE_BIN  = 1'b0;
  localparam logic MODE_GRAY = 1'b1;

  localparam int NREQ = 2;

endpackage

// File: rtl/count_encoder.sv
// Index-to-Count encoder: binary passthrough or binary-to-Gray.
// Purely combinational; the arbiter registers the result.
module count_encoder
  import count_run_arbiter_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] idx,
  input  logic             mode,
  output logic [WIDTH-1:0] count
);

  // Gray code is the index XOR'd with itself shifted down by one.
  always_comb begin
    count = idx;
    if (mode == MODE_GRAY) count = idx ^ (idx >> 1);
  end

endmodule

// File: rtl/count_run_arbiter.sv
// Round-robin arbiter and sequencer for the shared 3-bit binary/Gray counter.
// Optional feature macro: COUNT_HOLD_EN adds a Hold input that freezes a run.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no owner; pick a requester (round-robin on tie)
// LOAD    | owner latched, Count forced to 0
// RUN     | index advances each edge until it equals the latched length
// DONE    | one-cycle Done pulse to the owner, Count holds final value
module count_run_arbiter
  import count_run_arbiter_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic [NREQ-1:0]  Req,
  input  logic [NREQ-1:0]  Mode,
  input  logic [WIDTH-1:0] Len0,
  input  logic [WIDTH-1:0] Len1,
`ifdef COUNT_HOLD_EN
  input  logic             Hold,
`endif
  output logic [NREQ-1:0]  Grant,
  output logic [NREQ-1:0]  Done,
  output logic             Busy,
  output logic [WIDTH-1:0] Count,
  output logic             CountMode
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic             mode_q, mode_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] count_q, count_d;

  logic             hold_w;
  logic             sel;
  logic [WIDTH-1:0] idx_inc;
  logic [WIDTH-1:0] count_inc;

`ifdef COUNT_HOLD_EN
  assign hold_w = Hold;
`else
  assign hold_w = 1'b0;
`endif

  // On a tie the requester that was not served last wins.
  assign sel     = (Req == 2'b11) ? ~last_q : Req[1];
  assign idx_inc = idx_q + WIDTH'(1);

  // Encode the next index so Count changes on the same edge as idx.
  count_encoder #(.WIDTH(WIDTH)) u_enc (
    .idx   (idx_inc),
    .mode  (mode_q),
    .count (count_inc)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    mode_d  = mode_q;
    owner_d = owner_q;
    last_d  = last_q;
    grant_d = grant_q;
    done_d  = '0;
    busy_d  = busy_q;
    count_d = count_q;

    unique case (state_q)
      ST_IDLE: begin
        if (Req != '0) begin
          owner_d = sel;
          last_d  = sel;
          mode_d  = Mode[sel];
          len_d   = sel ? Len1 : Len0;
          idx_d   = '0;
          count_d = '0;
          grant_d = sel ? 2'b10 : 2'b01;
          busy_d  = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (!Req[owner_q]) begin
          idx_d   = '0;
          count_d = '0;
          grant_d = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (len_q == '0) begin
          done_d  = grant_q;
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!Req[owner_q]) begin
          idx_d   = '0;
          count_d = '0;
          grant_d = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (hold_w) begin
          state_d = ST_RUN;
        end else if (idx_q == len_q) begin
          done_d  = grant_q;
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_inc;
          count_d = count_inc;
        end
      end
      ST_DONE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers, falling-edge clocked, async active-low reset.
  always_ff @(negedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      mode_q  <= MODE_BIN;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign Grant     = grant_q;
  assign Done      = done_q;
  assign Busy      = busy_q;
  assign Count     = count_q;
  assign CountMode = mode_q;

endmodule

// File: tb/tb_count_run_arbiter.sv
// Directed bench for count_run_arbiter; DUT flops on the falling edge,
// outputs are sampled and inputs driven on the rising edge.
module tb_count_run_arbiter;

  logic       Clk = 1'b1;
  logic       nReset = 1'b0;
  logic [1:0] Req = 2'b00;
  logic [1:0] Mode = 2'b00;
  logic [2:0] Len0 = 3'd0;
  logic [2:0] Len1 = 3'd0;
`ifdef COUNT_HOLD_EN
  logic       Hold = 1'b0;
`endif
  logic [1:0] Grant;
  logic [1:0] Done;
  logic       Busy;
  logic [2:0] Count;
  logic       CountMode;

  int checks = 0;
  int failures = 0;
  int gray_tab [8] = '{0, 1, 3, 2, 6, 7, 5, 4};

  count_run_arbiter #(.WIDTH(3)) dut (
    .Clk       (Clk),
    .nReset    (nReset),
    .Req       (Req),
    .Mode      (Mode),
    .Len0      (Len0),
    .Len1      (Len1),
`ifdef COUNT_HOLD_EN
    .Hold      (Hold),
`endif
    .Grant     (Grant),
    .Done      (Done),
    .Busy      (Busy),
    .Count     (Count),
    .CountMode (CountMode)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
  endtask

  function automatic int expv(input logic m, input int k);
    return m ? gray_tab[k] : k;
  endfunction

  // One complete run from IDLE; after the grant the owner's Mode/Len are
  // scrambled to show they were latched.
  task automatic run_one(input int who, input logic m, input int len,
                         input logic [1:0] req_v, input bit drop);
    int g;
    g = (who == 1) ? 2 : 1;
    Mode[who] = m;
    if (who == 0) Len0 = len[2:0];
    else          Len1 = len[2:0];
    Req = req_v;
    tick();
    chk("grant", int'(Grant), g);
    chk("busy_load", int'(Busy), 1);
    chk("count_load", int'(Count), 0);
    chk("countmode_load", int'(CountMode), int'(m));
    chk("done_load", int'(Done), 0);
    Mode[who] = ~m;
    if (who == 0) Len0 = ~Len0;
    else          Len1 = ~Len1;
    if (len != 0) begin
      tick();
      chk("count_run0", int'(Count), 0);
      for (int k = 1; k <= len; k++) begin
        tick();
        chk("count_run", int'(Count), expv(m, k));
        chk("done_run", int'(Done), 0);
        chk("countmode_run", int'(CountMode), int'(m));
      end
    end
    tick();
    chk("done_pulse", int'(Done), g);
    chk("count_done", int'(Count), expv(m, len));
    if (drop) Req = 2'b00;
    tick();
    chk("done_clear", int'(Done), 0);
    chk("grant_idle", int'(Grant), 0);
    chk("busy_idle", int'(Busy), 0);
    chk("count_hold", int'(Count), expv(m, len));
  endtask

  initial begin
    tick();
    tick();
    chk("rst_grant", int'(Grant), 0);
    chk("rst_done", int'(Done), 0);
    chk("rst_busy", int'(Busy), 0);
    chk("rst_count", int'(Count), 0);
    chk("rst_countmode", int'(CountMode), 0);
    nReset = 1'b1;
    tick();

    // binary full run, then Gray full run
    run_one(0, 1'b0, 7, 2'b01, 1'b1);
    run_one(1, 1'b1, 7, 2'b10, 1'b1);

    // both requesting: alternate 0,1,0,1 with an idle cycle between runs
    Mode = 2'b00;
    for (int i = 0; i < 4; i++) run_one(i % 2, 1'b0, 2, 2'b11, i == 3);

    // abort requester 0 at Count=3
    Mode[0] = 1'b0;
    Len0 = 3'd6;
    Req = 2'b01;
    tick();
    chk("abort_grant", int'(Grant), 1);
    tick();
    for (int k = 0; k < 3; k++) tick();
    chk("abort_count3", int'(Count), 3);
    Req = 2'b00;
    tick();
    chk("abort_count", int'(Count), 0);
    chk("abort_grant0", int'(Grant), 0);
    chk("abort_done", int'(Done), 0);
    chk("abort_busy", int'(Busy), 0);

    // aborted owner counted as served, so a tie now goes to requester 1
    run_one(1, 1'b0, 2, 2'b11, 1'b1);

    // zero-length run: LOAD then DONE
    run_one(0, 1'b1, 0, 2'b01, 1'b1);

`ifdef COUNT_HOLD_EN
    Mode[0] = 1'b0;
    Len0 = 3'd5;
    Req = 2'b01;
    tick();
    tick();
    tick();
    tick();
    chk("hold_pre", int'(Count), 2);
    Hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hold_count", int'(Count), 2);
      chk("hold_busy", int'(Busy), 1);
    end
    Hold = 1'b0;
    for (int k = 3; k <= 5; k++) begin
      tick();
      chk("hold_resume", int'(Count), k);
    end
    tick();
    chk("hold_done", int'(Done), 1);
    Req = 2'b00;
    tick();
    chk("hold_done_clear", int'(Done), 0);
`endif

    // asynchronous reset in the middle of a run at Count=4
    Mode[0] = 1'b0;
    Len0 = 3'd7;
    Req = 2'b01;
    tick();
    tick();
    for (int k = 0; k < 4; k++) tick();
    chk("midrst_pre", int'(Count), 4);
    #2 nReset = 1'b0;
    #1;
    chk("midrst_count", int'(Count), 0);
    chk("midrst_grant", int'(Grant), 0);
    chk("midrst_done", int'(Done), 0);
    chk("midrst_busy", int'(Busy), 0);
    Req = 2'b00;
    tick();
    nReset = 1'b1;
    tick();
    chk("postrst_count", int'(Count), 0);
    chk("postrst_grant", int'(Grant), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/count_run_arbiter.md
Name: count_run_arbiter

Overview:
- Controller for the shared 3-bit binary/Gray mode counter datapath.
- Two requesters each request a "count run": a mode (binary or Gray) and a terminal index.
- The block arbitrates round-robin, sequences the run and drives the shared Count bus, then reports completion per requester.
- Sits between requester FSMs and the display/decode logic that consumes Count.

Parameters:
- WIDTH, 3: counter width; Count, Len0 and Len1 are WIDTH bits.

Ports:
- Clk  input  1  clock; all flops update on the falling edge.
- nReset  input  1  asynchronous active-low reset.
- Req  input  2  run request, bit i = requester i; must be held until Done[i].
- Mode  input  2  bit i: 0 = binary, 1 = Gray, for requester i.
- Len0  input  WIDTH  terminal index for requester 0.
- Len1  input  WIDTH  terminal index for requester 1.
- Grant  output  2  one-hot owner of the counter, 0 when idle.
- Done  output  2  one-cycle completion pulse to the owner.
- Busy  output  1  high in LOAD, RUN and DONE.
- Count  output  WIDTH  registered counter value, binary or Gray-encoded index.
- CountMode  output  1  latched mode of the current run.

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-low on nReset.
- Reset values: state IDLE, Count 0, Grant 0, Done 0, Busy 0, CountMode 0, idx 0, last-served pointer = 1 (requester 0 wins the first tie).
- Internal registers: idx (WIDTH-bit binary index), lenReg, modeReg, owner.
- Encoding: Count = modeReg ? (idx ^ (idx >> 1)) : idx. Gray order for WIDTH=3 is 000,001,011,010,110,111,101,100.
- IDLE:
  - If Req != 0, select the owner: the single requester; on a tie, the requester not equal to last-served.
  - Latch that requester's Mode bit and Len, set Grant one-hot, update last-served, go to LOAD.
- LOAD:
  - idx = 0, Count = 0, Busy = 1.
  - If lenReg == 0, go to DONE; otherwise go to RUN.
- RUN:
  - Each edge, idx increments by 1 and Count updates in the same edge.
  - When the new idx == lenReg, go to DONE.
  - A run emits lenReg+1 values (0..lenReg). idx never wraps, because lenReg ≤ 2^WIDTH−1.
- DONE:
  - Done[owner] = 1 for exactly one cycle; Count holds the final value.
  - Next edge: Grant = 0, Busy = 0, go to IDLE.
  - Count keeps the final value until the next LOAD.
- Latency: Grant rises 1 edge after Req is sampled in IDLE. Done rises lenReg+2 edges after Grant (lenReg=0: 1 edge).
- Back-to-back requests: IDLE is always visited for one cycle between runs; no Req is sampled in DONE.
- Abort: if Req[owner] falls in LOAD or RUN, the next edge goes to IDLE with Count = 0, Grant = 0, no Done. Last-served still counts the aborted owner.
- Ignored inputs: Mode/Len changes after the grant are ignored (values are latched). Req of the non-owner is ignored until IDLE.
- Reset mid-run forces the reset values immediately, with no Done.

Optional Feature:
- COUNT_HOLD_EN defined:
  - Adds input port Hold (1 bit).
  - In RUN, Hold = 1 freezes idx, Count and state; the abort check stays active.
  - Hold has no effect in the other states.
- COUNT_HOLD_EN not defined: no Hold port; RUN always advances.

Decomposition:
- Shared package:
  - state enum IDLE/LOAD/RUN/DONE (2-bit)
  - mode constants MODE_BIN = 0, MODE_GRAY = 1
  - NREQ = 2
- Sub-module count_encoder: combinational idx/mode → Count (binary passthrough or bin-to-Gray), WIDTH-parameterised, registered by the parent.

Test Plan:
- Req=01, Mode=00, Len0=7 → Grant=01; Count 0,1,2,…,7 on successive falling edges; Done=01 for one cycle; then Busy=0, Count holds 7.
- Req=10, Mode=10, Len1=7 → Count 000,001,011,010,110,111,101,100; Done=10; CountMode=1 throughout.
- Req=11 held from reset, Len0=Len1=2 → grants alternate 01,10,01,10; each run emits 0,1,2; one idle cycle between runs.
- Req=01, Len0=0 → LOAD then DONE; Count=0; Done=01 two edges after Req sampled.
- Req=01, Len0=6, drop Req[0] when Count=3 → next edge Count=0, Grant=00, Done stays 00; then Req=10 is granted normally.
- nReset low mid-run (Count=4) → Count, Grant, Done, Busy go to 0 immediately. With COUNT_HOLD_EN, Hold=1 for 3 cycles at Count=2 keeps Count=2, then counting resumes at 3.
